// File: rtl/mips_ld_pkg.sv
// Shared definitions for the load align unit: load-type codes, FSM state encoding,
// default timeout and the alignment predicate used when alignment checking is built in.
// Ports: none (package).
package mips_ld_pkg;

  // Load-type codes as presented on ld_type_M; codes 101..111 fall through to lw.
  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LBU = 3'b001;
  localparam logic [2:0] LD_LB  = 3'b010;
  localparam logic [2:0] LD_LHU = 3'b011;
  localparam logic [2:0] LD_LH  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } ld_state_t;

  localparam int DEFAULT_TIMEOUT = 15;

  // Natural alignment: bytes always, halfwords on even addresses, words on multiples of 4.
  function automatic logic ld_aligned(input logic [2:0] ld_type, input logic [1:0] addr_lo);
    case (ld_type)
      LD_LB, LD_LBU: ld_aligned = 1'b1;
      LD_LH, LD_LHU: ld_aligned = ~addr_lo[0];
      default:       ld_aligned = (addr_lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_align_unit_if.sv
// Data-memory read port between the load align unit (master) and memory (slave).
// Ports: mem_req/mem_addr from the unit; mem_ack/mem_rdata back from memory,
// rdata valid in the same cycle as the one-cycle ack.
interface load_align_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/load_ext.sv
// Purpose: pick the addressed byte/halfword out of a read word and sign/zero extend it.
// Latency: combinational.
// Backpressure: none.
// Ports: ld_type (load-type code), addr_lo (byte offset), word (memory word) -> data.
module load_ext
  import mips_ld_pkg::*;
(
  input  logic [2:0]  ld_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase

    // Halfwords only look at addr_lo[1]; an odd halfword address is truncated.
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    case (ld_type)
      LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  data = {24'h0, byte_sel};
      LD_LH:   data = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  data = {16'h0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// Purpose: M-stage load sequencer: issues a word read, extracts/extends the result for W.
// Latency: request-to-ld_valid_W is 2 cycles minimum (1 + memory ack delay); abandoned after TIMEOUT_CYC WAIT cycles.
// Backpressure: stall is held while a request is being accepted and throughout WAIT.
// Ports: clk, reset (sync, active-high); ld_req_M/ld_type_M/addr_M request; mem (master side of
// load_align_unit_if); stall; ld_valid_W/ld_data_W result; ld_timeout pulse; ld_err pulse only
// when LOADUNIT_ALIGN_CHECK_EN is defined (misaligned requests are then rejected in IDLE).
module load_align_unit
  import mips_ld_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ld_req_M,
  input  logic [2:0]               ld_type_M,
  input  logic [31:0]              addr_M,
  load_align_unit_if.master        mem,
  output logic                     stall,
  output logic                     ld_valid_W,
  output logic [31:0]              ld_data_W,
  output logic                     ld_timeout
`ifdef LOADUNIT_ALIGN_CHECK_EN
  ,
  output logic                     ld_err
`endif
);

  // Last WAIT count value; a WAIT cycle without ack at this count is the final one.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

  ld_state_t   state;
  logic [2:0]  type_q;
  logic [1:0]  addr_lo_q;
  logic [7:0]  wait_cnt;
  logic [31:0] ext_data;
  logic        req_ok;

`ifdef LOADUNIT_ALIGN_CHECK_EN
  assign req_ok = ld_aligned(ld_type_M, addr_M[1:0]);
`else
  assign req_ok = 1'b1;
`endif

  assign stall = ((state == ST_IDLE) && ld_req_M && req_ok) || (state == ST_WAIT);

  // Extraction works on the captured type/offset and the live read word, so the
  // result is ready to register on the ack edge.
  load_ext u_load_ext (
    .ld_type (type_q),
    .addr_lo (addr_lo_q),
    .word    (mem.mem_rdata),
    .data    (ext_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      wait_cnt     <= 8'h0;
      type_q       <= LD_LW;
      addr_lo_q    <= 2'b00;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= 32'h0;
      ld_valid_W   <= 1'b0;
      ld_data_W    <= 32'h0;
      ld_timeout   <= 1'b0;
`ifdef LOADUNIT_ALIGN_CHECK_EN
      ld_err       <= 1'b0;
`endif
    end else begin
      ld_valid_W <= 1'b0;
      ld_timeout <= 1'b0;
`ifdef LOADUNIT_ALIGN_CHECK_EN
      ld_err     <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (ld_req_M) begin
            if (req_ok) begin
              state        <= ST_WAIT;
              wait_cnt     <= 8'h0;
              type_q       <= ld_type_M;
              addr_lo_q    <= addr_M[1:0];
              mem.mem_req  <= 1'b1;
              mem.mem_addr <= {addr_M[31:2], 2'b00};
            end
`ifdef LOADUNIT_ALIGN_CHECK_EN
            else begin
              ld_err <= 1'b1;
            end
`endif
          end
        end
        ST_WAIT: begin
          // Ack is checked first so it wins over a timeout in the same cycle.
          if (mem.mem_ack) begin
            state       <= ST_DONE;
            mem.mem_req <= 1'b0;
            ld_valid_W  <= 1'b1;
            ld_data_W   <= ext_data;
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= ST_IDLE;
            mem.mem_req <= 1'b0;
            ld_timeout  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state       <= ST_IDLE;
          mem.mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
